accel_ctrl_regfile: RTL

//  Parametrised control/argument register file between the axi_lite_to_ssram bridge and an HLS accelerator.

---
 rtl/accel_ctrl_regfile.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/accel_ctrl_regfile.sv
// Control/argument register file between the SSRAM bridge and an HLS accelerator.
// Drives the start channel, latches done, counts busy cycles and raises irq.
module accel_ctrl_regfile #(
    parameter int NUM_ARGS   = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic [ADDR_WIDTH-1:0]   read_addr,
    input  logic                    read_en,
    output logic [31:0]             read_data,
    input  logic [ADDR_WIDTH-1:0]   write_addr,
    input  logic [31:0]             write_data,
    input  logic [3:0]              write_strb,
    input  logic                    write_en,
    output logic                    start_dat,
    output logic                    start_vld,
    input  logic                    start_rdy,
    input  logic                    done_dat,
    input  logic                    done_vld,
    output logic                    done_rdy,
    output logic [32*NUM_ARGS-1:0]  args,
    output logic                    irq
);

    localparam logic [ADDR_WIDTH-1:0] A_CTRL   = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] A_STATUS = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] A_DONE   = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] A_IRQEN  = ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] A_CYCLES = ADDR_WIDTH'(4);

    logic [31:0] arg_q [NUM_ARGS];
    logic        ctrl_q;
    logic        busy;
    logic        done_latched;
    logic        done_dat_q;
    logic        err;
    logic        irq_en;
    logic [31:0] cycles;

    logic        protect;
    logic        ctrl_hit;
    logic        arg_hit;
    logic        status_clr;
    logic        err_set;
    logic        start_acc;
    logic        done_acc;
    logic        done_clr;
    logic [31:0] rdata;

    // Argument and control writes are frozen from start request until done.
    assign protect    = start_vld | busy;
    assign ctrl_hit   = write_en && (write_addr == A_CTRL);
    assign status_clr = write_en && (write_addr == A_STATUS)
                        && write_strb[0] && write_data[4];
    assign err_set    = protect && (ctrl_hit || arg_hit);
    assign start_acc  = start_vld & start_rdy;
    assign done_acc   = done_vld & ~done_latched;
    assign done_clr   = read_en && (read_addr == A_DONE);

    assign done_rdy  = ~done_latched;
    assign start_dat = ctrl_q;

    always_comb begin
        arg_hit = 1'b0;
        for (int i = 0; i < NUM_ARGS; i++) begin
            if (write_en && (write_addr == ADDR_WIDTH'(8 + i))) begin
                arg_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_ARGS; i++) begin
                arg_q[i] <= '0;
            end
        end else if (arg_hit && !protect) begin
            for (int i = 0; i < NUM_ARGS; i++) begin
                if (write_addr == ADDR_WIDTH'(8 + i)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (write_strb[b]) begin
                            arg_q[i][8*b +: 8] <= write_data[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_ARGS; g++) begin : g_args
        assign args[32*g +: 32] = arg_q[g];
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ctrl_q    <= 1'b0;
            start_vld <= 1'b0;
            busy      <= 1'b0;
            cycles    <= '0;
        end else begin
            if (ctrl_hit && !protect) begin
                if (write_strb[0]) begin
                    ctrl_q <= write_data[0];
                end
                start_vld <= 1'b1;
            end else if (start_acc) begin
                start_vld <= 1'b0;
            end
            // A start accept beats a coincident done, leaving busy set.
            if (start_acc) begin
                busy <= 1'b1;
            end else if (done_acc) begin
                busy <= 1'b0;
            end
            if (start_acc) begin
                cycles <= '0;
            end else if (busy && (cycles != 32'hFFFF_FFFF)) begin
                cycles <= cycles + 32'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            done_latched <= 1'b0;
            done_dat_q   <= 1'b0;
            err          <= 1'b0;
            irq_en       <= 1'b0;
            irq          <= 1'b0;
        end else begin
            if (done_acc) begin
                done_latched <= 1'b1;
                done_dat_q   <= done_dat;
            end else if (done_clr) begin
                done_latched <= 1'b0;
            end
            if (err_set) begin
                err <= 1'b1;
            end else if (status_clr) begin
                err <= 1'b0;
            end
            if (write_en && (write_addr == A_IRQEN) && write_strb[0]) begin
                irq_en <= write_data[0];
            end
            irq <= done_latched & irq_en;
        end
    end

    always_comb begin
        rdata = '0;
        unique case (read_addr)
            A_CTRL:   rdata = {31'b0, ctrl_q};
            A_STATUS: rdata = {27'b0, err, done_dat_q, done_latched,
                               busy, start_vld};
            A_DONE:   rdata = {31'b0, done_latched};
            A_IRQEN:  rdata = {31'b0, irq_en};
            A_CYCLES: rdata = cycles;
            default: begin
                for (int i = 0; i < NUM_ARGS; i++) begin
                    if (read_addr == ADDR_WIDTH'(8 + i)) begin
                        rdata = arg_q[i];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            read_data <= '0;
        end else if (read_en) begin
            read_data <= rdata;
        end
    end

endmodule
